// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Registered instruction queue between fetch and decode. Fetch pushes
//   {instruction, pc} words with a valid/ready handshake. Decode sees the
//   head entry and its MIPS fields split out. A flush drops every entry,
//   which is used on a taken branch or jump.
//
//   Optional feature macro: IFQ_PREDECODE_EN
//     Defined:   each entry also holds a branch target computed at push time.
//     Undefined: there is no target storage or adder, and br_target is 0.
//
// Ports
//   clk, rst             rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready    fetch handshake; in_instr/in_pc carry the word
//   flush                clears the queue at the next edge (beats push and pop)
//   out_valid/out_ready  decode handshake for the head entry
//   out_instr/out_pc     head word, or 0 when the queue is empty
//   opcode..imm16        slices of out_instr
//   count                number of entries held (0..DEPTH)
//   br_target            predecoded target of the head entry (0 if disabled or empty)
module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [PTR_W:0]   count,
  output logic [31:0]      br_target
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [DEPTH-1:0][31:0] instr_q, instr_d;
  logic [DEPTH-1:0][29:0] pc_q, pc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;

  logic push;
  logic pop;

  // The pc low bits are always zero, so only pc[31:2] is stored.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^in_pc[1:0];

  // Ready and valid come only from the registered count. This keeps
  // out_ready off the in_ready path, so a full queue refuses a push even in
  // a cycle where it is popped.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = in_instr;
        pc_d[wr_ptr_q]    = in_pc[31:2];
        wr_ptr_d          = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The head outputs are gated by out_valid so that stale storage is never
  // visible. An empty queue shows a NOP at pc 0.
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? {pc_q[rd_ptr_q], 2'b00} : 32'h0;
  assign count     = count_q;

  assign opcode = out_instr[31:26];
  assign rs     = out_instr[25:21];
  assign rt     = out_instr[20:16];
  assign rd     = out_instr[15:11];
  assign shamt  = out_instr[10:6];
  assign funct  = out_instr[5:0];
  assign imm16  = out_instr[15:0];

`ifdef IFQ_PREDECODE_EN
  // The target is computed in word units: pc[31:2] + sext(imm16) + 1.
  // The +1 accounts for the delay-slot pc + 4. The sum wraps mod 2^30 words.
  logic [DEPTH-1:0][29:0] tgt_q, tgt_d;
  logic [29:0]            tgt_new;

  assign tgt_new = in_pc[31:2] + {{14{in_instr[15]}}, in_instr[15:0]} + 30'd1;

  always_comb begin
    tgt_d = tgt_q;
    if (!flush && push) begin
      tgt_d[wr_ptr_q] = tgt_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
    end
  end

  assign br_target = out_valid ? {tgt_q[rd_ptr_q], 2'b00} : 32'h0;
`else
  assign br_target = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [31:0]      in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd, shamt;
  logic [5:0]       funct;
  logic [15:0]      imm16;
  logic [PTR_W:0]   count;
  logic [31:0]      br_target;

  fetch_decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .count(count), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] instr, input logic [31:0] pc);
`ifdef IFQ_PREDECODE_EN
    logic [31:0] off;
    off = {{14{instr[15]}}, instr[15:0], 2'b00};
    return pc + 32'd4 + off;
`else
    return 32'h0 + (instr & 32'h0) + (pc & 32'h0);
`endif
  endfunction

  // Compare every output against the head of the reference queue.
  task automatic check_outputs();
    logic [31:0] ei, ep, et;
    ei = 32'h0; ep = 32'h0; et = 32'h0;
    if (mq.size() > 0) begin
      ei = mq[0].instr; ep = mq[0].pc; et = mq[0].tgt;
    end
    check_val("count", 32'(count), 32'(mq.size()));
    check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_val("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check_val("out_instr", out_instr, ei);
    check_val("out_pc", out_pc, ep);
    check_val("fields", {opcode, rs, rt, rd, shamt, funct},
              {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[10:6], ei[5:0]});
    check_val("imm16", 32'(imm16), 32'(ei[15:0]));
    check_val("br_target", br_target, et);
  endtask

  // Drive the inputs at the negedge, advance the model at the posedge, and
  // check the outputs at the following negedge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    do_push = iv && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{instr: ins, pc: pc, tgt: ref_target(ins, pc)});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [31:0] r_ins, r_pc, tgt_exp;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // Push a single lw word while decode is stalled.
    step(1, 32'h8C22_0004, 32'h0040_0020, 0, 0);
    check_val("lw_opcode", 32'(opcode), 32'h23);
    check_val("lw_rs", 32'(rs), 32'd1);
    check_val("lw_rt", 32'(rt), 32'd2);
    check_val("lw_imm", 32'(imm16), 32'h0004);
    check_val("lw_pc", out_pc, 32'h0040_0020);

    // Fill the queue; a third offer must be refused; pops come out in order.
    step(0, 0, 0, 0, 1);
    step(1, 32'h0000_0020, 32'h0040_0020, 0, 0);
    step(1, 32'h0000_0021, 32'h0040_0024, 0, 0);
    check_val("full_count", 32'(count), 32'd2);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    step(1, 32'h0000_0022, 32'h0040_0028, 0, 0);
    check_val("third_ignored", 32'(count), 32'd2);
    step(0, 0, 0, 1, 0);
    check_val("pop1_pc", out_pc, 32'h0040_0024);
    step(0, 0, 0, 1, 0);
    check_val("pop2_empty", 32'(out_valid), 32'd0);

    // With one entry held, push and pop in the same cycle. Repeat to wrap the pointers.
    step(1, 32'h1111_0000, 32'h0000_1000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h2222_0000 + 32'(i), 32'h0000_2000 + 32'(i * 4), 1, 0);
      check_val("pp_count", 32'(count), 32'd1);
      check_val("pp_pc", out_pc, 32'h0000_2000 + 32'(i * 4));
    end

    // Flush while full with a concurrent push.
    step(1, 32'h3333_0000, 32'h0000_3000, 0, 0);
    step(1, 32'h4444_0000, 32'h0000_4000, 1, 1);
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    check_val("flush_no_push", 32'(count), 32'd0);

    // Predecoded branch target (a beq with offset -1).
    step(1, 32'h1022_FFFF, 32'h0040_0028, 0, 0);
`ifdef IFQ_PREDECODE_EN
    tgt_exp = 32'h0040_0028;
`else
    tgt_exp = 32'h0;
`endif
    check_val("beq_target", br_target, tgt_exp);
    step(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r_ins = $urandom;
      r_pc  = $urandom & 32'hFFFF_FFFC;
      step(1'($urandom_range(0, 3) != 0), r_ins, r_pc,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // Assert the async reset mid-cycle with entries held.
    step(1, 32'h5555_0000, 32'h0000_5000, 0, 0);
    step(1, 32'h6666_0000, 32'h0000_6000, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    check_val("async_rst_count", 32'(count), 32'd0);
    check_val("async_rst_valid", 32'(out_valid), 32'd0);
    check_val("async_rst_ready", 32'(in_ready), 32'd1);
    check_val("async_rst_instr", out_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 32'h7777_0001, 32'h0000_7000, 0, 0);
    check_val("post_rst_pc", out_pc, 32'h0000_7000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
